// File: rtl/uart_io_fifo_pkg.sv
// Shared constants for the CPU/UART buffering bridge: register addresses,
// status bit positions and uart-side FSM states.
package uart_io_fifo_pkg;

  localparam logic ADDR_DATA = 1'b0;
  localparam logic ADDR_STAT = 1'b1;

  // UART status byte
  localparam int unsigned RX_READY = 0;
  localparam int unsigned TX_BUSY  = 1;

  // CPU-visible status byte
  localparam int unsigned RXNE = 0;
  localparam int unsigned TXF  = 1;
  localparam int unsigned DROP = 2;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    POLL  = 3'd1,
    EVAL  = 3'd2,
    RXRD  = 3'd3,
    RXCAP = 3'd4,
    TXWR  = 3'd5
  } state_e;

endpackage

// File: rtl/uart_io_fifo_sync_fifo.sv
// Single-clock FIFO with show-ahead head output; push when full and pop when
// empty are ignored, so the count can never wrap.
module sync_fifo #(
  parameter int unsigned DW         = 8,
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [DW-1:0] din,
  input  logic          pop,
  output logic [DW-1:0] dout,
  output logic          full,
  output logic          empty
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

  logic [DW-1:0]         mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic                  push_ok, pop_ok;

  assign full  = (count_q == (DEPTH_LOG2+1)'(DEPTH));
  assign empty = (count_q == '0);
  assign dout  = mem_q[rd_ptr_q];

  always_comb begin
    pop_ok   = pop && !empty;
    // a pop in the same cycle frees the slot the push needs
    push_ok  = push && (!full || pop_ok);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + DEPTH_LOG2'(1);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + (DEPTH_LOG2+1)'(1);
      2'b01:   count_d = count_q - (DEPTH_LOG2+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/uart_io_fifo.sv
// CPU <-> UART bridge: 16-deep TX/RX FIFOs on the CPU side and a polling
// FSM on the UART side that moves bytes with RX taking priority over TX.
module uart_io_fifo
  import uart_io_fifo_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 4,
  parameter int unsigned DW         = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_rd,
  input  logic          cpu_wr,
  input  logic          cpu_addr,
  input  logic [DW-1:0] cpu_din,
  output logic [DW-1:0] cpu_dout,
  output logic          u_rd,
  output logic          u_wr,
  output logic          u_addr,
  output logic [DW-1:0] u_din,
  input  logic [DW-1:0] u_dout
);

  logic [DW-1:0] tx_head, rx_head;
  logic          tx_full, tx_empty, rx_full, rx_empty;
  logic          tx_push, tx_pop, rx_push, rx_pop;
  logic          drop_q, drop_d;
  logic [DW-1:0] cpu_dout_q, cpu_dout_d;
  logic [DW-1:0] stat;
  state_e        state_q;
  logic          u_rd_q, u_wr_q, u_addr_q;
  logic [DW-1:0] u_din_q;

  sync_fifo #(.DW(DW), .DEPTH_LOG2(DEPTH_LOG2)) u_tx_fifo (
    .clk(clk), .rst(rst), .push(tx_push), .din(cpu_din), .pop(tx_pop),
    .dout(tx_head), .full(tx_full), .empty(tx_empty)
  );

  sync_fifo #(.DW(DW), .DEPTH_LOG2(DEPTH_LOG2)) u_rx_fifo (
    .clk(clk), .rst(rst), .push(rx_push), .din(u_dout), .pop(rx_pop),
    .dout(rx_head), .full(rx_full), .empty(rx_empty)
  );

  always_comb begin
    stat       = '0;
    stat[RXNE] = !rx_empty;
    stat[TXF]  = tx_full;
    stat[DROP] = drop_q;

    tx_push = cpu_wr && (cpu_addr == ADDR_DATA);
    drop_d  = drop_q;
    if (tx_push && tx_full) drop_d = 1'b1;
    if (cpu_wr && (cpu_addr == ADDR_STAT) && cpu_din[DROP]) drop_d = 1'b0;

    rx_pop     = 1'b0;
    cpu_dout_d = cpu_dout_q;
    if (cpu_rd) begin
      if (cpu_addr == ADDR_DATA) begin
        cpu_dout_d = rx_empty ? '0 : rx_head;
        rx_pop     = !rx_empty;
      end else begin
        cpu_dout_d = stat;
      end
    end

    // u_dout is valid in RXCAP because the data read strobe was issued in RXRD
    rx_push = (state_q == RXCAP);
    tx_pop  = (state_q == TXWR);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      drop_q     <= 1'b0;
      cpu_dout_q <= '0;
    end else begin
      drop_q     <= drop_d;
      cpu_dout_q <= cpu_dout_d;
    end
  end

  // Strobes are loaded on entry to a state so they are high for exactly that state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      u_rd_q   <= 1'b0;
      u_wr_q   <= 1'b0;
      u_addr_q <= ADDR_DATA;
      u_din_q  <= '0;
    end else begin
      u_rd_q <= 1'b0;
      u_wr_q <= 1'b0;
      case (state_q)
        IDLE: begin
          state_q  <= POLL;
          u_rd_q   <= 1'b1;
          u_addr_q <= ADDR_STAT;
        end
        POLL: state_q <= EVAL;
        EVAL: begin
          if (u_dout[RX_READY] && !rx_full) begin
            state_q  <= RXRD;
            u_rd_q   <= 1'b1;
            u_addr_q <= ADDR_DATA;
          end else if (!u_dout[TX_BUSY] && !tx_empty) begin
            state_q  <= TXWR;
            u_wr_q   <= 1'b1;
            u_addr_q <= ADDR_DATA;
            u_din_q  <= tx_head;
          end else begin
            state_q <= IDLE;
          end
        end
        RXRD:    state_q <= RXCAP;
        RXCAP:   state_q <= IDLE;
        TXWR:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cpu_dout = cpu_dout_q;
  assign u_rd     = u_rd_q;
  assign u_wr     = u_wr_q;
  assign u_addr   = u_addr_q;
  assign u_din    = u_din_q;

endmodule

// File: tb/tb_uart_io_fifo.sv
// Directed bench for uart_io_fifo with a behavioural UART register model.
module tb_uart_io_fifo;

  logic       clk = 1'b0;
  logic       rst, cpu_rd, cpu_wr, cpu_addr;
  logic [7:0] cpu_din, cpu_dout, u_din;
  logic [7:0] u_dout = '0;
  logic       u_rd, u_wr, u_addr;

  int n_assert = 0;
  int n_fail   = 0;

  // UART model state
  int         cyc = 0;
  logic       tx_busy = 1'b0;
  logic [7:0] rx_mem [64];
  int         rx_wr = 0;
  int         rx_rd = 0;
  int         n_rxrd = 0;
  logic [7:0] tx_log [64];
  int         tx_cyc [64];
  int         tx_n = 0;
  int         last_wr_cyc = 0;

  uart_io_fifo #(.DEPTH_LOG2(4), .DW(8)) dut (
    .clk(clk), .rst(rst), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr),
    .cpu_addr(cpu_addr), .cpu_din(cpu_din), .cpu_dout(cpu_dout),
    .u_rd(u_rd), .u_wr(u_wr), .u_addr(u_addr), .u_din(u_din),
    .u_dout(u_dout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (u_rd) begin
      if (u_addr) begin
        u_dout <= {6'b0, tx_busy, (rx_rd != rx_wr)};
      end else begin
        n_rxrd <= n_rxrd + 1;
        if (rx_rd != rx_wr) begin
          u_dout <= rx_mem[rx_rd];
          rx_rd  <= rx_rd + 1;
        end else begin
          u_dout <= 8'h00;
        end
      end
    end
    if (u_wr) begin
      tx_log[tx_n] <= u_din;
      tx_cyc[tx_n] <= cyc;
      tx_n         <= tx_n + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cpu_write(input logic a, input logic [7:0] d);
    @(negedge clk);
    cpu_addr    = a;
    cpu_din     = d;
    cpu_wr      = 1'b1;
    last_wr_cyc = cyc;
    @(negedge clk);
    cpu_wr = 1'b0;
  endtask

  task automatic cpu_read(input logic a, output logic [7:0] d);
    @(negedge clk);
    cpu_addr = a;
    cpu_rd   = 1'b1;
    @(negedge clk);
    cpu_rd = 1'b0;
    d      = cpu_dout;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] d;
    int         w0, base;
    logic       got;

    rst = 1'b1; cpu_rd = 1'b0; cpu_wr = 1'b0; cpu_addr = 1'b0; cpu_din = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_cpu_dout", 32'(cpu_dout), 32'h0);
    chk("rst_u_rd",     32'(u_rd),     32'h0);
    chk("rst_u_wr",     32'(u_wr),     32'h0);
    chk("rst_u_addr",   32'(u_addr),   32'h0);
    chk("rst_u_din",    32'(u_din),    32'h0);
    rst = 1'b0;
    cpu_read(1'b1, d);
    chk("rst_status", 32'(d), 32'h00);

    // TX path
    cpu_write(1'b0, 8'h41);
    w0 = last_wr_cyc;
    cpu_write(1'b0, 8'h42);
    for (int i = 0; i < 40 && tx_n < 2; i++) @(negedge clk);
    chk("tx_count", 32'(tx_n), 32'd2);
    chk("tx_byte0", 32'(tx_log[0]), 32'h41);
    chk("tx_byte1", 32'(tx_log[1]), 32'h42);
    chk("tx_lat0", 32'(tx_cyc[0] - w0 <= 6), 32'd1);
    chk("tx_lat1", 32'(tx_cyc[1] - tx_cyc[0] <= 6), 32'd1);

    // RX path
    base = n_rxrd;
    rx_mem[rx_wr] = 8'h5A;
    rx_wr = rx_wr + 1;
    repeat (6) @(negedge clk);
    cpu_read(1'b1, d);
    chk("rx_status_ne", 32'(d), 32'h01);
    chk("rx_data_reads", 32'(n_rxrd - base), 32'd1);
    cpu_read(1'b0, d);
    chk("rx_data", 32'(d), 32'h5A);
    cpu_read(1'b1, d);
    chk("rx_status_empty", 32'(d), 32'h00);
    cpu_read(1'b0, d);
    chk("rx_read_empty", 32'(d), 32'h00);

    // TX overflow while UART busy
    tx_busy = 1'b1;
    repeat (4) @(negedge clk);
    for (int i = 0; i < 17; i++) cpu_write(1'b0, 8'(i));
    cpu_read(1'b1, d);
    chk("ovf_status", 32'(d), 32'h06);
    chk("ovf_no_tx_busy", 32'(tx_n), 32'd2);
    cpu_write(1'b1, 8'h04);
    cpu_read(1'b1, d);
    chk("ovf_drop_clear", 32'(d), 32'h02);
    tx_busy = 1'b0;
    for (int i = 0; i < 200 && tx_n < 18; i++) @(negedge clk);
    repeat (30) @(negedge clk);
    chk("ovf_tx_count", 32'(tx_n), 32'd18);
    for (int i = 0; i < 16; i++) chk($sformatf("ovf_tx_byte%0d", i), 32'(tx_log[2+i]), 32'(i));
    cpu_read(1'b1, d);
    chk("ovf_status_after", 32'(d), 32'h00);

    // RX backpressure
    base = n_rxrd;
    for (int i = 0; i < 18; i++) rx_mem[rx_wr + i] = 8'(8'h80 + i);
    rx_wr = rx_wr + 18;
    repeat (150) @(negedge clk);
    chk("bp_reads_held", 32'(n_rxrd - base), 32'd16);
    cpu_read(1'b1, d);
    chk("bp_status", 32'(d), 32'h01);
    for (int i = 0; i < 16; i++) begin
      cpu_read(1'b0, d);
      chk($sformatf("bp_drain%0d", i), 32'(d), 32'(8'h80 + i));
    end
    repeat (40) @(negedge clk);
    for (int i = 16; i < 18; i++) begin
      cpu_read(1'b0, d);
      chk($sformatf("bp_drain%0d", i), 32'(d), 32'(8'h80 + i));
    end
    chk("bp_reads_total", 32'(n_rxrd - base), 32'd18);
    cpu_read(1'b1, d);
    chk("bp_status_after", 32'(d), 32'h00);

    // Reset during TXWR
    tx_busy = 1'b1;
    cpu_write(1'b0, 8'hC3);
    cpu_write(1'b0, 8'hC4);
    repeat (4) @(negedge clk);
    tx_busy = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = u_wr;
    end
    chk("mr_txwr_seen", 32'(got), 32'd1);
    chk("mr_txwr_byte", 32'(u_din), 32'hC3);
    rst = 1'b1;
    @(negedge clk);
    chk("mr_u_rd",     32'(u_rd),     32'h0);
    chk("mr_u_wr",     32'(u_wr),     32'h0);
    chk("mr_u_addr",   32'(u_addr),   32'h0);
    chk("mr_u_din",    32'(u_din),    32'h0);
    chk("mr_cpu_dout", 32'(cpu_dout), 32'h0);
    rst = 1'b0;
    base = tx_n;
    repeat (40) @(negedge clk);
    chk("mr_no_more_tx", 32'(tx_n), 32'(base));
    cpu_read(1'b1, d);
    chk("mr_status", 32'(d), 32'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_io_fifo.md
Name: uart_io_fifo

Overview:
- Buffering bridge between the CPU I/O port and the UART core's register port.
- Gives the CPU a 16-deep TX FIFO and a 16-deep RX FIFO, so byte bursts do not stall on UART timing.
- A uart-side state machine polls UART status and moves bytes in both directions.
- Instantiated at top level between cpu_top and miniuart2. It is clocked by the 50 MHz system clock and reset by the power-on reset counter.

Parameters:
- DEPTH_LOG2, 4, log2 of each FIFO depth (16 entries).
- DW, 8, data width; equals UartDataWidth.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- cpu_rd  in  1  CPU read strobe, one cycle
- cpu_wr  in  1  CPU write strobe, one cycle
- cpu_addr  in  1  0 = data, 1 = status/control
- cpu_din  in  DW  CPU write data
- cpu_dout  out  DW  CPU read data, registered
- u_rd  out  1  read strobe to UART
- u_wr  out  1  write strobe to UART
- u_addr  out  1  UART register select: 0 = data, 1 = status
- u_din  out  DW  byte to UART
- u_dout  in  DW  UART read data; valid on the cycle after u_rd

Behaviour:
- Reset (synchronous, active-high):
  - Both FIFOs empty; pointers and counts 0.
  - cpu_dout = 0, u_rd = 0, u_wr = 0, u_addr = 0, u_din = 0.
  - drop flag = 0; FSM in IDLE.
  - Reset asserted mid-transfer aborts the transfer. The byte in flight is lost; no partial strobe is issued after reset.
- CPU write, addr 0: push cpu_din to the TX FIFO.
  - If TX is full: byte discarded, sticky drop flag set.
- CPU write, addr 1: if cpu_din[2] = 1, clear the drop flag; other bits ignored.
- CPU read, addr 0: cpu_dout <= RX head on the next cycle, and RX pops.
  - If RX is empty: cpu_dout <= 0, no pop.
- CPU read, addr 1: cpu_dout <= {5'b0, drop, tx_full, rx_nonempty} on the next cycle.
- FIFO pointers: DEPTH_LOG2 bits, natural wrap. Count is DEPTH_LOG2+1 bits.
  - full = (count == 16); empty = (count == 0).
- Simultaneous push and pop on the same FIFO in one cycle: both take effect, count unchanged. This is legal when full (RX) or empty (TX) only for the side that is possible.
- UART status byte: bit0 = rx_ready, bit1 = tx_busy.
- Uart-side FSM; strobes are one cycle wide and registered:
  - IDLE: go to POLL.
  - POLL: u_rd = 1, u_addr = 1. Go to EVAL.
  - EVAL: sample u_dout.
    - If rx_ready and RX not full: go to RXRD.
    - Else if !tx_busy and TX not empty: go to TXWR.
    - Else: go to IDLE.
    - RX has priority over TX.
  - RXRD: u_rd = 1, u_addr = 0. Go to RXCAP.
  - RXCAP: push u_dout to RX. Go to IDLE.
  - TXWR: u_wr = 1, u_addr = 0, u_din = TX head; TX pops. Go to IDLE.
- When RX is full, the UART byte is left unread (backpressure); the FIFO never overflows.
- Latency:
  - CPU write to u_wr: at most 6 cycles with an idle UART and empty RX path.
  - UART byte to rx_nonempty: at most 6 cycles.

Decomposition:
- Shared package/define file:
  - UART status bit indices (RX_READY = 0, TX_BUSY = 1).
  - Register addresses (ADDR_DATA = 0, ADDR_STAT = 1).
  - CPU status bit indices (RXNE = 0, TXF = 1, DROP = 2).
  - FSM state encodings.
- One sub-module: sync_fifo (DW, DEPTH_LOG2), instantiated twice for TX and RX.

Test Plan:
- Reset: after rst, expect all outputs 0. A status read (addr 1) returns 0x00.
- TX path: CPU writes 0x41, 0x42 with the UART model reporting tx_busy = 0.
  - Expect u_wr pulses carrying u_din = 0x41 then 0x42, in order, each within 6 cycles of eligibility.
- RX path: the UART model presents rx_ready with byte 0x5A.
  - Expect RXRD then RXCAP; status bit0 = 1.
  - A CPU read of addr 0 returns 0x5A; status then reads 0x00.
- TX overflow: hold tx_busy = 1 and write 17 bytes 0x00..0x10.
  - Status reads 0x06.
  - Write addr 1 with 0x04: status reads 0x02.
  - Release busy: exactly 0x00..0x0F are transmitted.
- RX backpressure: inject 18 bytes without CPU reads.
  - FSM stops issuing data reads after 16.
  - Draining yields the 16 bytes in order; the remaining 2 are then fetched.
- Mid-operation reset: assert rst on the TXWR cycle.
  - Next cycle all strobes are 0 and FIFOs are empty; no further u_wr without new writes.
